gp_table_db: RTL and testbench

Double-buffered, parametrised general-purpose parameter table for the control unit. Software-side writes land in a shadow bank. The active bank drives the timing datapath (t_up, t_on[n], …) and is updated atomically from the shadow bank only at a datapath period boundary (`sync`) after a commit request. This prevents the datapath from ever seeing a half-updated parameter set mid-period. A bypass mode and registered shadow readback support bring-up and debug.

---
 rtl/gp_table_db.sv | 129 ++++++++++++
 tb/tb_gp_table_db.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/gp_table_db.sv
// Double-buffered parameter table: software writes a shadow bank, and the active bank
// driving the datapath is reloaded from it atomically at a period boundary after a commit.
module gp_table_db #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter int               AW        = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          N_reset,
  input  logic                          we,
  input  logic [AW-1:0]                 wa,
  input  logic [WIDTH-1:0]              wd,
  input  logic [WIDTH/8-1:0]            wbe,
  input  logic                          commit,
  input  logic                          sync,
  input  logic                          bypass,
  input  logic [AW-1:0]                 ra,
  output logic [WIDTH-1:0]              rdata,
  output logic [0:DEPTH-1][WIDTH-1:0]   rd,
  output logic                          pending,
  output logic                          dirty,
  output logic                          committed,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int            NB      = WIDTH / 8;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  // The FSM state is visible externally as `pending` (ARMED == pending).
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [0:DEPTH-1][WIDTH-1:0] r_shadow;
  logic [0:DEPTH-1][WIDTH-1:0] r_active;
  logic [WIDTH-1:0]            r_rdata;
  logic                        r_dirty;
  logic                        r_committed;
  logic                        r_err;

  logic                        w_wa_ok;
  logic                        w_ra_ok;
  logic                        w_wr;
  logic                        w_copy;
  logic                        w_err_new;
  logic [WIDTH-1:0]            w_shadow_wdata;
  logic [WIDTH-1:0]            w_active_base;
  logic [WIDTH-1:0]            w_byp_wdata;

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] base,
                                                   input logic [WIDTH-1:0] data,
                                                   input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = base;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  assign w_wa_ok   = ({1'b0, wa} < DEPTH_W);
  assign w_ra_ok   = ({1'b0, ra} < DEPTH_W);
  assign w_wr      = we && w_wa_ok;
  assign w_err_new = (we && !w_wa_ok) || !w_ra_ok;

  assign w_shadow_wdata = merge_bytes(r_shadow[wa], wd, wbe);
  // A bypass write lands on whatever rd[wa] would otherwise become this edge.
  assign w_active_base  = w_copy ? r_shadow[wa] : r_active[wa];
  assign w_byp_wdata    = merge_bytes(w_active_base, wd, wbe);

  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (commit) begin
          if (sync) w_copy = 1'b1;
          else      w_state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sync) begin
          w_copy      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge N_reset) begin
    if (!N_reset) begin
      r_state     <= S_IDLE;
      r_shadow    <= {DEPTH{RESET_VAL}};
      r_active    <= {DEPTH{RESET_VAL}};
      r_rdata     <= '0;
      r_dirty     <= 1'b0;
      r_committed <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Later assignments win: a bypass write overrides the copy for its entry.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_copy) r_active[i] <= r_shadow[i];
        if (w_wr && bypass && (wa == AW'(i))) r_active[i] <= w_byp_wdata;
        if (w_wr && (wa == AW'(i))) r_shadow[i] <= w_shadow_wdata;
      end
      r_rdata     <= w_ra_ok ? r_shadow[ra] : '0;
      r_committed <= w_copy;
      if (w_wr && !bypass) r_dirty <= 1'b1;
      else if (w_copy)     r_dirty <= 1'b0;
      if (w_err_new)       r_err <= 1'b1;
      else if (err_clr)    r_err <= 1'b0;
    end
  end

  assign rd        = r_active;
  assign rdata     = r_rdata;
  assign pending   = (r_state == S_ARMED);
  assign dirty     = r_dirty;
  assign committed = r_committed;
  assign err       = r_err;

endmodule

// File: tb/tb_gp_table_db.sv
// Bench for gp_table_db (DEPTH=3 so out-of-range addresses are reachable):
// table of byte-masked writes with readback, then commit/sync/bypass/error/reset sequences.
module tb_gp_table_db;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int AW    = 2;

  logic                        clk;
  logic                        N_reset;
  logic                        we;
  logic [AW-1:0]               wa;
  logic [WIDTH-1:0]            wd;
  logic [WIDTH/8-1:0]          wbe;
  logic                        commit;
  logic                        sync;
  logic                        bypass;
  logic [AW-1:0]               ra;
  logic [WIDTH-1:0]            rdata;
  logic [0:DEPTH-1][WIDTH-1:0] rd;
  logic                        pending;
  logic                        dirty;
  logic                        committed;
  logic                        err;
  logic                        err_clr;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0]      wa;
    logic [WIDTH-1:0]   wd;
    logic [WIDTH/8-1:0] wbe;
    logic [WIDTH-1:0]   exp;
  } vec_t;
  vec_t vecs[6];

  gp_table_db #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .N_reset(N_reset), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .commit(commit), .sync(sync), .bypass(bypass), .ra(ra), .rdata(rdata),
    .rd(rd), .pending(pending), .dirty(dirty), .committed(committed),
    .err(err), .err_clr(err_clr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                    input logic [WIDTH/8-1:0] be, input logic byp);
    we = 1'b1; wa = a; wd = d; wbe = be; bypass = byp;
    tick();
    we = 1'b0; bypass = 1'b0;
  endtask

  // Scoreboard: expectation queued with the read address, checked after the registering edge.
  task automatic readback(input logic [AW-1:0] a, input logic [WIDTH-1:0] e, input string nm);
    ra = a;
    exp_q.push_back(e);
    tick();
    if (exp_q.size() == 0) begin
      n_checks++; n_errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      check(nm, rdata, exp_q.pop_front());
    end
  endtask

  initial begin
    vecs[0] = '{wa: 2'd2, wd: 32'h11223344, wbe: 4'hF, exp: 32'h11223344};
    vecs[1] = '{wa: 2'd2, wd: 32'hAABBCCDD, wbe: 4'b0101, exp: 32'h11BB33DD};
    vecs[2] = '{wa: 2'd0, wd: 32'hDEADBEEF, wbe: 4'b0011, exp: 32'h0000BEEF};
    vecs[3] = '{wa: 2'd0, wd: 32'h12345678, wbe: 4'b1000, exp: 32'h1200BEEF};
    vecs[4] = '{wa: 2'd1, wd: 32'hFFFFFFFF, wbe: 4'b0000, exp: 32'h000003E8};
    vecs[5] = '{wa: 2'd1, wd: 32'h0000AA00, wbe: 4'b0010, exp: 32'h0000AAE8};

    N_reset = 1'b0; we = 1'b0; wa = '0; wd = '0; wbe = '0; commit = 1'b0;
    sync = 1'b0; bypass = 1'b0; ra = '0; err_clr = 1'b0;
    repeat (3) tick();
    check("rst_pending", pending, 0);
    check("rst_dirty", dirty, 0);
    check("rst_committed", committed, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    for (int i = 0; i < DEPTH; i++) check("rst_rd", rd[i], 0);
    N_reset = 1'b1;
    tick();

    // first write lands in shadow only
    wr(2'd1, 32'h000003E8, 4'hF, 1'b0);
    check("wr_dirty", dirty, 1);
    check("wr_rd1_unchanged", rd[1], 0);
    readback(2'd1, 32'h000003E8, "rb_first");

    // table-driven byte-masked writes
    for (int v = 0; v < 6; v++) begin
      wr(vecs[v].wa, vecs[v].wd, vecs[v].wbe, 1'b0);
      readback(vecs[v].wa, vecs[v].exp, "rb_vec");
    end
    check("tbl_rd_still_zero", rd[2], 0);

    // commit then later sync
    check("pre_commit_dirty", dirty, 1);
    commit = 1'b1; tick(); commit = 1'b0;
    check("armed_pending", pending, 1);
    check("armed_committed", committed, 0);
    check("armed_rd2", rd[2], 0);
    tick();
    check("armed_pending2", pending, 1);
    commit = 1'b1; tick(); commit = 1'b0;
    check("armed_recommit_pending", pending, 1);
    check("armed_recommit_rd0", rd[0], 0);
    tick();
    check("armed_pending4", pending, 1);
    sync = 1'b1; tick(); sync = 1'b0;
    check("copy_pending", pending, 0);
    check("copy_committed", committed, 1);
    check("copy_dirty", dirty, 0);
    check("copy_rd0", rd[0], 32'h1200BEEF);
    check("copy_rd1", rd[1], 32'h0000AAE8);
    check("copy_rd2", rd[2], 32'h11BB33DD);
    tick();
    check("copy_committed_pulse", committed, 0);
    check("sync_idle_no_change", rd[1], 32'h0000AAE8);

    // commit + sync + write in one cycle
    wr(2'd0, 32'd5, 4'hF, 1'b0);
    commit = 1'b1; sync = 1'b1; we = 1'b1; wa = 2'd0; wd = 32'd7; wbe = 4'hF;
    tick();
    commit = 1'b0; sync = 1'b0; we = 1'b0;
    check("imm_rd0", rd[0], 32'd5);
    check("imm_pending", pending, 0);
    check("imm_dirty", dirty, 1);
    check("imm_committed", committed, 1);
    readback(2'd0, 32'd7, "imm_shadow0");

    // out-of-range accesses and err
    commit = 1'b1; sync = 1'b1; tick(); commit = 1'b0; sync = 1'b0;
    check("copy2_rd0", rd[0], 32'd7);
    check("copy2_dirty", dirty, 0);
    wr(2'd3, 32'hFFFFFFFF, 4'hF, 1'b0);
    check("oor_err", err, 1);
    check("oor_dirty", dirty, 0);
    check("oor_rd2", rd[2], 32'h11BB33DD);
    readback(2'd2, 32'h11BB33DD, "oor_shadow2");
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("err_clr", err, 0);
    err_clr = 1'b1;
    readback(2'd3, 32'd0, "oor_read_zero");
    check("err_wins_over_clr", err, 1);
    ra = 2'd0; tick(); err_clr = 1'b0;
    check("err_clr2", err, 0);

    // bypass writes
    wr(2'd1, 32'd9, 4'hF, 1'b1);
    check("byp_rd1", rd[1], 32'd9);
    check("byp_dirty", dirty, 0);
    check("byp_pending", pending, 0);
    readback(2'd1, 32'd9, "byp_shadow1");
    wr(2'd2, 32'h22, 4'hF, 1'b0);
    check("byp_pre_dirty", dirty, 1);
    commit = 1'b1; sync = 1'b1; bypass = 1'b1;
    we = 1'b1; wa = 2'd2; wd = 32'h33; wbe = 4'hF;
    tick();
    commit = 1'b0; sync = 1'b0; bypass = 1'b0; we = 1'b0;
    check("byp_copy_rd2", rd[2], 32'h33);
    check("byp_copy_rd0", rd[0], 32'd7);
    check("byp_copy_rd1", rd[1], 32'd9);
    check("byp_copy_dirty", dirty, 0);
    check("byp_copy_committed", committed, 1);
    readback(2'd2, 32'h33, "byp_copy_shadow2");

    // reset while armed
    wr(2'd0, 32'hABC, 4'hF, 1'b0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("pre_rst_pending", pending, 1);
    #2 N_reset = 1'b0;
    #1;
    check("async_rst_pending", pending, 0);
    check("async_rst_rd0", rd[0], 0);
    check("async_rst_rd2", rd[2], 0);
    check("async_rst_dirty", dirty, 0);
    check("async_rst_rdata", rdata, 0);
    repeat (2) tick();
    N_reset = 1'b1;
    sync = 1'b1; tick(); sync = 1'b0;
    check("post_rst_sync_rd0", rd[0], 0);
    check("post_rst_sync_committed", committed, 0);
    check("post_rst_sync_pending", pending, 0);
    readback(2'd0, 32'd0, "post_rst_shadow0");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
